avm_cmd_master: RTL
===================

# avm_cmd_master

Avalon-MM master that turns a byte-oriented command stream into single 32-bit Avalon read/write transfers and returns responses as a byte stream. It sits between a UART core's receive/transmit byte interfaces and the Avalon interconnect, so a host on the serial link can access memory-mapped slaves such as the UART register block. It is the initiator side for the team's Avalon slaves and honours `waitrequest` with a bounded timeout.

## Interface
- ADDR_W, 8, Avalon address width; 1..8; taken from the low ADDR_W bits of the address byte.
- TIMEOUT, 255, consecutive `waitrequest`-high cycles before the transfer is abandoned; 0 disables the timeout.

- clk  input  1  sole clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_valid  input  1  command byte valid.
- rx_data  input  8  command byte.
- rx_ready  output  1  command byte accepted when `rx_valid & rx_ready`.
- tx_valid  output  1  response byte valid.
- tx_data  output  8  response byte.
- tx_ready  input  1  response byte taken when `tx_valid & tx_ready`.
- avm_m0_address  output  ADDR_W  transfer address.
- avm_m0_read  output  1  read request.
- avm_m0_write  output  1  write request.
- avm_m0_writedata  output  32  write data.
- avm_m0_readdata  input  32  read data; valid in the cycle `waitrequest` is low during a read.
- avm_m0_waitrequest  input  1  slave stall.
- busy  output  1  high in any state other than IDLE.

## Operation
- Packet formats:
  - Write: 0x57 ('W'), addr, d0, d1, d2, d3. Data is little-endian, so d0 goes to writedata[7:0].
  - Read: 0x52 ('R'), addr.
- Responses:
  - Write done: one byte, 0x4B ('K').
  - Read done: four bytes, readdata[7:0] first.
  - Timeout: one byte, 0x54 ('T').
  - Unknown opcode: the byte is consumed, then one byte 0x3F ('?') is sent.
- States:
  - IDLE: wait for the opcode.
  - ADDR: take the address byte.
  - WDATA: 2-bit byte counter, 0..3.
  - BUS: Avalon request is active.
  - RESP: 2-bit byte counter, last index 0 or 3.
- Transitions:
  - IDLE goes to ADDR on 'W' or 'R'; on any other opcode it goes to RESP carrying '?'.
  - ADDR goes to WDATA for a write and to BUS for a read.
  - WDATA goes to BUS after d3.
  - BUS goes to RESP on completion or timeout.
  - RESP goes to IDLE after the last byte is transferred.
- `rx_ready` = 1 exactly in IDLE, ADDR and WDATA. No bytes are accepted in BUS or RESP; the upstream stalls.
- In BUS, exactly one of `read`/`write` is high. `address`/`writedata` are registered and held stable for the whole transfer.
- Timeout counter:
  - Cleared on entry to BUS.
  - Increments each BUS cycle with `waitrequest`=1.
  - When it reaches TIMEOUT, the request drops next cycle and 'T' is sent.
- Response byte source:
  - For a read, `readdata` is captured into a 32-bit register on the completing edge.
  - The response byte is muxed from that register by the RESP counter.

## Timing
- Reset values:
  - State IDLE, so `rx_ready`=1.
  - `tx_valid`, `tx_data`, `avm_m0_read`, `avm_m0_write`, `avm_m0_address`, `avm_m0_writedata`, `busy` all 0.
  - Counters and the capture register 0.
- Request timing: if the last command byte is accepted at edge N, `read`/`write` is high from cycle N+1.
- Completion:
  - A transfer completes at the first edge where `waitrequest`=0 while the request is high.
  - The request is low the cycle after; there are no back-to-back or repeated transfers.
- Zero-wait slave: request is high one cycle; `tx_valid` rises at N+2.
- `tx_valid`/`tx_data` are held stable until `tx_ready`. The next byte is presented the following cycle, so one byte is sent per cycle if `tx_ready` is tied high.
- After the final handshake `tx_valid`=0 and the block returns to IDLE. A new opcode can be accepted the next cycle.
- `rx_valid` is ignored while `rx_ready`=0. Bytes arriving in BUS/RESP are not lost by this block; holding them is the upstream's job.
- Timeout and `waitrequest` falling in the same cycle the count reaches TIMEOUT: completion wins, and the normal response is sent.
- TIMEOUT=0: BUS waits indefinitely.
- Reset asserted mid-operation:
  - `read`/`write`/`tx_valid` drop immediately (asynchronously).
  - A partial packet and any pending response are discarded.

## Test plan
- Write, zero-wait: 'W',0x04,0x78,0x56,0x34,0x12. Required: one write cycle with address=0x04 and writedata=0x12345678, starting 1 cycle after the last byte; then 'K'.
- Read, 3 wait cycles: 'R',0x02 with readdata=0xA1B2C3D4 when `waitrequest` falls. Required: read held 4 cycles with address stable; response bytes 0xD4,0xC3,0xB2,0xA1.
- Timeout: TIMEOUT=5, `waitrequest` stuck high. Required: read high for exactly 5 cycles; then 'T'; block back in IDLE.
- Bad opcode and response backpressure: send 0x00. Required: '?' response. Hold `tx_ready` low 10 cycles. Required: `tx_valid`/`tx_data` stable throughout and `rx_ready`=0.
- Reset mid-transfer: assert reset during BUS of a write. Required: write low immediately, all outputs at their reset values. A subsequent 'R' packet then works normally.

Source files
------------

// File: rtl/avm_cmd_master_if.sv
// Byte-stream command/response channel plus Avalon-MM master bus for avm_cmd_master.
// The master modport is the bridge's view; the slave modport is the surrounding system's view.
interface avm_cmd_master_if #(
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic [ADDR_W-1:0] avm_m0_address;
  logic              avm_m0_read;
  logic              avm_m0_write;
  logic [31:0]       avm_m0_writedata;
  logic [31:0]       avm_m0_readdata;
  logic              avm_m0_waitrequest;

  modport master (
    input  rx_valid, rx_data, tx_ready, avm_m0_readdata, avm_m0_waitrequest,
    output rx_ready, tx_valid, tx_data, avm_m0_address, avm_m0_read,
           avm_m0_write, avm_m0_writedata
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, avm_m0_readdata, avm_m0_waitrequest,
    input  rx_ready, tx_valid, tx_data, avm_m0_address, avm_m0_read,
           avm_m0_write, avm_m0_writedata
  );
endinterface

// File: rtl/avm_cmd_master.sv
// Serial-command Avalon-MM master: 'W' addr d0..d3 / 'R' addr packets become single
// 32-bit transfers, answered with 'K', four read bytes, 'T' (timeout) or '?' (bad opcode).
module avm_cmd_master #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  avm_cmd_master_if.master   bus,
  output logic               busy
);

  localparam logic [7:0] OP_WR  = 8'h57;
  localparam logic [7:0] OP_RD  = 8'h52;
  localparam logic [7:0] RSP_OK = 8'h4B;
  localparam logic [7:0] RSP_TO = 8'h54;
  localparam logic [7:0] RSP_BAD = 8'h3F;
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} state_t;

  state_t            state;
  logic              is_wr;
  logic [1:0]        cnt;
  logic [1:0]        last_idx;
  logic [TO_W-1:0]   to_cnt;
  logic [31:0]       rdata;
  logic [31:0]       wdata;
  logic [ADDR_W-1:0] addr;
  logic              rd_q;
  logic              wr_q;
  logic              txv_q;
  logic [7:0]        txd_q;

  logic       rx_fire;
  logic       tx_fire;
  logic       req_tmo;
  logic [1:0] cnt_nxt;

  assign bus.rx_ready         = (state == IDLE) || (state == ADDR) || (state == WDATA);
  assign bus.tx_valid         = txv_q;
  assign bus.tx_data          = txd_q;
  assign bus.avm_m0_address   = addr;
  assign bus.avm_m0_read      = rd_q;
  assign bus.avm_m0_write     = wr_q;
  assign bus.avm_m0_writedata = wdata;
  assign busy                 = (state != IDLE);

  assign rx_fire = bus.rx_valid & bus.rx_ready;
  assign tx_fire = txv_q & bus.tx_ready;
  assign cnt_nxt = cnt + 2'd1;
  // Completion is tested first in BUS, so a slave releasing on the final count still wins.
  assign req_tmo = (TIMEOUT != 0) && bus.avm_m0_waitrequest && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      is_wr    <= 1'b0;
      cnt      <= 2'd0;
      last_idx <= 2'd0;
      to_cnt   <= '0;
      rdata    <= '0;
      wdata    <= '0;
      addr     <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      txv_q    <= 1'b0;
      txd_q    <= '0;
    end else begin
      case (state)
        IDLE: if (rx_fire) begin
          if (bus.rx_data == OP_WR || bus.rx_data == OP_RD) begin
            is_wr <= (bus.rx_data == OP_WR);
            state <= ADDR;
          end else begin
            txd_q    <= RSP_BAD;
            txv_q    <= 1'b1;
            cnt      <= 2'd0;
            last_idx <= 2'd0;
            state    <= RESP;
          end
        end
        ADDR: if (rx_fire) begin
          addr   <= bus.rx_data[ADDR_W-1:0];
          cnt    <= 2'd0;
          to_cnt <= '0;
          if (is_wr) begin
            state <= WDATA;
          end else begin
            rd_q  <= 1'b1;
            state <= BUS;
          end
        end
        WDATA: if (rx_fire) begin
          wdata[{cnt, 3'b000} +: 8] <= bus.rx_data;
          cnt <= cnt_nxt;
          if (cnt == 2'd3) begin
            wr_q   <= 1'b1;
            to_cnt <= '0;
            state  <= BUS;
          end
        end
        BUS: begin
          cnt <= 2'd0;
          if (!bus.avm_m0_waitrequest) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            txv_q <= 1'b1;
            state <= RESP;
            if (is_wr) begin
              txd_q    <= RSP_OK;
              last_idx <= 2'd0;
            end else begin
              rdata    <= bus.avm_m0_readdata;
              txd_q    <= bus.avm_m0_readdata[7:0];
              last_idx <= 2'd3;
            end
          end else if (req_tmo) begin
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            txv_q    <= 1'b1;
            txd_q    <= RSP_TO;
            last_idx <= 2'd0;
            state    <= RESP;
          end else if (TIMEOUT != 0) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        RESP: if (tx_fire) begin
          if (cnt == last_idx) begin
            txv_q <= 1'b0;
            state <= IDLE;
          end else begin
            cnt   <= cnt_nxt;
            txd_q <= rdata[{cnt_nxt, 3'b000} +: 8];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
